stim_seq_ctrl: RTL

//  Programmable stimulus sequencer for the SVA repetition labs. Drives the start/x/y signals

---
 rtl/stim_seq_pkg.sv | 26 ++
 rtl/stim_pat_table.sv | 31 +++
 rtl/stim_seq_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stim_seq_pkg.sv
// Shared types for the stimulus sequencer: pattern-table entry layout,
// sequencer state encoding and the run-length legality rule.
package stim_seq_pkg;

  localparam int PAT_DEPTH  = 8;
  localparam int PAT_HOLD_W = 4;

  typedef struct packed {
    logic                  x;
    logic                  y;
    logic [PAT_HOLD_W-1:0] hold;
  } pat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // A run must play at least one entry and no more than the table holds.
  function automatic logic len_legal(input int len, input int depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/stim_pat_table.sv
// Pattern table: DEPTH entries of pat_t, one synchronous write port,
// one combinational read port, cleared to zero by reset.
module stim_pat_table
  import stim_seq_pkg::*;
#(
  parameter  int DEPTH = PAT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pat_t          wdata,
  input  logic [AW-1:0] raddr,
  output pat_t          rdata
);

  pat_t mem [DEPTH];

  // Entry storage; reset wipes every entry so a stale pattern can never replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stim_seq_ctrl.sv
// Stimulus sequencer: on go, emits a one-cycle start pulse, then replays
// run_len table entries on x/y, each held for hold+1 cycles, then pulses done.
//
//  state | meaning
//  IDLE  | waiting for go; table writable; outputs low; ready=1
//  START | start pulse visible; entry 0 loaded on the next edge
//  PLAY  | x/y show table[idx]; hold_cnt counts its remaining cycles
//  DONE  | done pulse visible; x/y low; back to IDLE next edge
module stim_seq_ctrl
  import stim_seq_pkg::*;
#(
  parameter  int DEPTH  = PAT_DEPTH,
  parameter  int HOLD_W = PAT_HOLD_W,  // must match PAT_HOLD_W (pat_t layout)
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic              cfg_x,
  input  logic              cfg_y,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              go,
  input  logic [AW:0]       run_len,
  input  logic              abort,
  output logic              ready,
  output logic              start,
  output logic              x,
  output logic              y,
  output logic              done,
  output logic              err
);

  seq_state_t        state;
  logic [AW:0]       idx;
  logic [AW:0]       nxt_idx;
  logic [AW:0]       len_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [AW-1:0]     rd_addr;
  pat_t              rd_pat;
  pat_t              wr_pat;
  logic              len_ok;
  logic              go_ok;

  assign ready   = (state == IDLE);
  assign len_ok  = len_legal(int'(run_len), DEPTH);
  assign go_ok   = go && ready && len_ok;
  assign nxt_idx = idx + {{AW{1'b0}}, 1'b1};
  // START always fetches entry 0; PLAY prefetches the entry that follows idx.
  assign rd_addr = (state == START) ? '0 : nxt_idx[AW-1:0];
  assign wr_pat  = {cfg_x, cfg_y, cfg_hold};

  // Table writes are only honoured in IDLE so a run sees a frozen table.
  stim_pat_table #(.DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && ready),
    .waddr (cfg_addr),
    .wdata (wr_pat),
    .raddr (rd_addr),
    .rdata (rd_pat)
  );

  // Sequencer FSM, entry/hold counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      len_q    <= '0;
      hold_cnt <= '0;
      start    <= 1'b0;
      x        <= 1'b0;
      y        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err   <= (cfg_we && !ready) || (go && ready && !len_ok);
      start <= 1'b0;
      done  <= 1'b0;
      if (abort && !ready) begin
        state <= IDLE;
        x     <= 1'b0;
        y     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go_ok) begin
              state <= START;
              start <= 1'b1;
              len_q <= run_len;
              idx   <= '0;
            end
          end
          START: begin
            state    <= PLAY;
            x        <= rd_pat.x;
            y        <= rd_pat.y;
            hold_cnt <= rd_pat.hold;
          end
          PLAY: begin
            if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - 1'b1;
            end else if (nxt_idx == len_q) begin
              state <= DONE;
              x     <= 1'b0;
              y     <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx      <= nxt_idx;
              x        <= rd_pat.x;
              y        <= rd_pat.y;
              hold_cnt <= rd_pat.hold;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
